// File: rtl/rmt_pkt_pkg.sv
// rtl/rmt_pkt_pkg.sv - header field offsets, protocol constants and filter FSM encoding
package rmt_pkt_pkg;

   localparam int ETH_TYPE_LSB  = 128;
   localparam int IP_PROTO_LSB  = 216;
   localparam int UDP_DPORT_LSB = 320;

   // Constants are in wire byte order as they appear in the little-endian beat
   localparam logic [7:0]  IP_PROTO_UDP  = 8'h11;
   localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0008;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_FWD_DATA = 2'd1,
      ST_FWD_CTRL = 2'd2,
      ST_DROP     = 2'd3
   } state_t;

endpackage

// File: rtl/axis_out_reg.sv
// rtl/axis_out_reg.sv - one-deep registered AXI-Stream output stage with full backpressure
module axis_out_reg #(
   parameter int DW = 512,
   parameter int UW = 128
) (
   input  logic            clk,
   input  logic            aresetn,
   input  logic [DW-1:0]   s_tdata,
   input  logic [DW/8-1:0] s_tkeep,
   input  logic [UW-1:0]   s_tuser,
   input  logic            s_tlast,
   input  logic            s_tvalid,
   output logic            s_tready,
   output logic [DW-1:0]   m_tdata,
   output logic [DW/8-1:0] m_tkeep,
   output logic [UW-1:0]   m_tuser,
   output logic            m_tlast,
   output logic            m_tvalid,
   input  logic            m_tready
);

   logic [DW-1:0]   r_tdata;
   logic [DW/8-1:0] r_tkeep;
   logic [UW-1:0]   r_tuser;
   logic            r_tlast;
   logic            r_tvalid;

   // Free when empty or when the held beat leaves this cycle
   assign s_tready = !r_tvalid || m_tready;

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         r_tdata  <= '0;
         r_tkeep  <= '0;
         r_tuser  <= '0;
         r_tlast  <= 1'b0;
         r_tvalid <= 1'b0;
      end else if (s_tvalid && s_tready) begin
         r_tdata  <= s_tdata;
         r_tkeep  <= s_tkeep;
         r_tuser  <= s_tuser;
         r_tlast  <= s_tlast;
         r_tvalid <= 1'b1;
      end else if (m_tready) begin
         r_tvalid <= 1'b0;
      end
   end

   assign m_tdata  = r_tdata;
   assign m_tkeep  = r_tkeep;
   assign m_tuser  = r_tuser;
   assign m_tlast  = r_tlast;
   assign m_tvalid = r_tvalid;

endmodule

// File: rtl/ctrl_pkt_filter.sv
// rtl/ctrl_pkt_filter.sv - splits ingress packets into data and control streams on the first beat
module ctrl_pkt_filter
   import rmt_pkt_pkg::*;
#(
   parameter int          C_S_AXIS_DATA_WIDTH  = 512,
   parameter int          C_S_AXIS_TUSER_WIDTH = 128,
   parameter logic [15:0] CTRL_UDP_PORT        = 16'hf1f2,
   parameter int          CNT_WIDTH            = 32
) (
   input  logic                                 clk,
   input  logic                                 aresetn,
   input  logic [C_S_AXIS_DATA_WIDTH-1:0]       s_axis_tdata,
   input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]     s_axis_tkeep,
   input  logic [C_S_AXIS_TUSER_WIDTH-1:0]      s_axis_tuser,
   input  logic                                 s_axis_tvalid,
   output logic                                 s_axis_tready,
   input  logic                                 s_axis_tlast,
   output logic [C_S_AXIS_DATA_WIDTH-1:0]       m_axis_tdata,
   output logic [C_S_AXIS_DATA_WIDTH/8-1:0]     m_axis_tkeep,
   output logic [C_S_AXIS_TUSER_WIDTH-1:0]      m_axis_tuser,
   output logic                                 m_axis_tvalid,
   input  logic                                 m_axis_tready,
   output logic                                 m_axis_tlast,
   output logic [C_S_AXIS_DATA_WIDTH-1:0]       c_m_axis_tdata,
   output logic [C_S_AXIS_DATA_WIDTH/8-1:0]     c_m_axis_tkeep,
   output logic [C_S_AXIS_TUSER_WIDTH-1:0]      c_m_axis_tuser,
   output logic                                 c_m_axis_tvalid,
   input  logic                                 c_m_axis_tready,
   output logic                                 c_m_axis_tlast,
   input  logic                                 ctrl_en,
   output logic [CNT_WIDTH-1:0]                 data_pkt_cnt,
   output logic [CNT_WIDTH-1:0]                 ctrl_pkt_cnt,
   output logic [CNT_WIDTH-1:0]                 drop_pkt_cnt
);

   localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   state_t                r_state;
   state_t                w_state_nxt;
   state_t                w_route;
   logic                  r_ready_en;
   logic                  w_is_ctrl;
   logic                  w_data_rdy;
   logic                  w_ctrl_rdy;
   logic                  w_acc;
   logic                  w_data_vld;
   logic                  w_ctrl_vld;
   logic [CNT_WIDTH-1:0]  r_data_cnt;
   logic [CNT_WIDTH-1:0]  r_ctrl_cnt;
   logic [CNT_WIDTH-1:0]  r_drop_cnt;

   assign w_is_ctrl = (s_axis_tdata[ETH_TYPE_LSB +: 16]  == ETH_TYPE_IPV4) &&
                      (s_axis_tdata[IP_PROTO_LSB +: 8]   == IP_PROTO_UDP)  &&
                      (s_axis_tdata[UDP_DPORT_LSB +: 16] == CTRL_UDP_PORT);

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) r_state <= ST_IDLE;
      else          r_state <= w_state_nxt;
   end

   // Only IDLE looks at the beat; mid-packet the route is whatever the first beat chose
   always_comb begin
      w_route       = r_state;
      s_axis_tready = 1'b0;
      w_state_nxt   = r_state;
      if (r_state == ST_IDLE) begin
         if (!w_is_ctrl)   w_route = ST_FWD_DATA;
         else if (ctrl_en) w_route = ST_FWD_CTRL;
         else              w_route = ST_DROP;
      end
      case (w_route)
         ST_FWD_DATA: s_axis_tready = r_ready_en && w_data_rdy;
         ST_FWD_CTRL: s_axis_tready = r_ready_en && w_ctrl_rdy;
         default:     s_axis_tready = r_ready_en;
      endcase
      if (s_axis_tvalid && s_axis_tready)
         w_state_nxt = s_axis_tlast ? ST_IDLE : w_route;
   end

   assign w_acc      = s_axis_tvalid && s_axis_tready;
   assign w_data_vld = s_axis_tvalid && r_ready_en && (w_route == ST_FWD_DATA);
   assign w_ctrl_vld = s_axis_tvalid && r_ready_en && (w_route == ST_FWD_CTRL);

   // r_ready_en keeps tready low while reset is held and for the cycle it releases
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         r_ready_en <= 1'b0;
         r_data_cnt <= '0;
         r_ctrl_cnt <= '0;
         r_drop_cnt <= '0;
      end else begin
         r_ready_en <= 1'b1;
         if (w_acc && s_axis_tlast) begin
            case (w_route)
               ST_FWD_DATA: if (r_data_cnt != '1) r_data_cnt <= r_data_cnt + CNT_ONE;
               ST_FWD_CTRL: if (r_ctrl_cnt != '1) r_ctrl_cnt <= r_ctrl_cnt + CNT_ONE;
               ST_DROP:     if (r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + CNT_ONE;
               default:     ;
            endcase
         end
      end
   end

   assign data_pkt_cnt = r_data_cnt;
   assign ctrl_pkt_cnt = r_ctrl_cnt;
   assign drop_pkt_cnt = r_drop_cnt;

   axis_out_reg #(.DW(C_S_AXIS_DATA_WIDTH), .UW(C_S_AXIS_TUSER_WIDTH)) u_data_out (
      .clk      (clk),
      .aresetn  (aresetn),
      .s_tdata  (s_axis_tdata),
      .s_tkeep  (s_axis_tkeep),
      .s_tuser  (s_axis_tuser),
      .s_tlast  (s_axis_tlast),
      .s_tvalid (w_data_vld),
      .s_tready (w_data_rdy),
      .m_tdata  (m_axis_tdata),
      .m_tkeep  (m_axis_tkeep),
      .m_tuser  (m_axis_tuser),
      .m_tlast  (m_axis_tlast),
      .m_tvalid (m_axis_tvalid),
      .m_tready (m_axis_tready)
   );

   axis_out_reg #(.DW(C_S_AXIS_DATA_WIDTH), .UW(C_S_AXIS_TUSER_WIDTH)) u_ctrl_out (
      .clk      (clk),
      .aresetn  (aresetn),
      .s_tdata  (s_axis_tdata),
      .s_tkeep  (s_axis_tkeep),
      .s_tuser  (s_axis_tuser),
      .s_tlast  (s_axis_tlast),
      .s_tvalid (w_ctrl_vld),
      .s_tready (w_ctrl_rdy),
      .m_tdata  (c_m_axis_tdata),
      .m_tkeep  (c_m_axis_tkeep),
      .m_tuser  (c_m_axis_tuser),
      .m_tlast  (c_m_axis_tlast),
      .m_tvalid (c_m_axis_tvalid),
      .m_tready (c_m_axis_tready)
   );

endmodule
